// File: rtl/fetch_pc_unit_pkg.sv
// Shared types and constants for the IF-stage PC owner.
package fetch_pc_unit_pkg;

   // Default datapath width and instruction size in bytes.
   localparam int unsigned XLEN_DEF   = 32;
   localparam int unsigned INSN_BYTES = 4;
   localparam int unsigned CNT_W_DEF  = 32;

   // Fetch control states; FETCH_TRAP is only reachable with FETCH_MISALIGN_TRAP_EN.
   typedef enum logic [1:0] {
      FETCH_BOOT = 2'd0,
      FETCH_RUN  = 2'd1,
      FETCH_TRAP = 2'd2
   } fetch_state_e;

   // Source of the next PC (which is also the address presented to IMEM).
   typedef enum logic [1:0] {
      PC_SEL_RESET = 2'd0,
      PC_SEL_TGT   = 2'd1,
      PC_SEL_HOLD  = 2'd2,
      PC_SEL_INC   = 2'd3
   } pc_sel_e;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Fetch-unit bus: hazard/redirect inputs from the pipeline, IMEM request and
// IF/EX tagging outputs. master = fetch unit side, slave = pipeline side.
interface fetch_pc_unit_if
   import fetch_pc_unit_pkg::*;
#(
   parameter int unsigned XLEN  = XLEN_DEF,
   parameter int unsigned CNT_W = CNT_W_DEF
);

   logic             stall;
   logic             redir_valid;
   logic [XLEN-1:0]  redir_target;
   logic             imem_en;
   logic [XLEN-1:0]  imem_addr;
   logic [XLEN-1:0]  if_pc;
   logic             if_valid;
   logic [CNT_W-1:0] fetch_cnt;
   logic             fetch_exc;
   logic [XLEN-1:0]  exc_pc;

   modport master (
      input  stall,
      input  redir_valid,
      input  redir_target,
      output imem_en,
      output imem_addr,
      output if_pc,
      output if_valid,
      output fetch_cnt,
      output fetch_exc,
      output exc_pc
   );

   modport slave (
      output stall,
      output redir_valid,
      output redir_target,
      input  imem_en,
      input  imem_addr,
      input  if_pc,
      input  if_valid,
      input  fetch_cnt,
      input  fetch_exc,
      input  exc_pc
   );

endinterface

// File: rtl/fetch_pc_unit_pc_next_mux.sv
// Combinational next-PC select: reset vector, redirect target, hold, or PC+4.
module pc_next_mux
   import fetch_pc_unit_pkg::*;
#(
   parameter int unsigned XLEN = XLEN_DEF
) (
   input  pc_sel_e         sel_i,
   input  logic [XLEN-1:0] reset_pc_i,
   input  logic [XLEN-1:0] tgt_i,
   input  logic [XLEN-1:0] pc_q_i,
   output logic [XLEN-1:0] pc_next_o
);

   logic [XLEN-1:0] pc_inc;

   // Sequential increment wraps modulo 2^XLEN with no flag.
   assign pc_inc = pc_q_i + XLEN'(INSN_BYTES);

   // Priority has already been resolved into sel_i by the control FSM.
   always_comb begin
      pc_next_o = pc_q_i;
      case (sel_i)
         PC_SEL_RESET: pc_next_o = reset_pc_i;
         PC_SEL_TGT:   pc_next_o = tgt_i;
         PC_SEL_HOLD:  pc_next_o = pc_q_i;
         PC_SEL_INC:   pc_next_o = pc_inc;
         default:      pc_next_o = pc_q_i;
      endcase
   end

endmodule

// File: rtl/fetch_pc_unit.sv
// IF-stage program-counter owner. Holds the PC, drives the synchronous-read
// IMEM address, applies EX-stage redirects, tags each fetched word with its PC
// and a valid bit, and counts valid fetches.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN -- misaligned redirect targets
// trap (TRAP state, fetch_exc/exc_pc) instead of being silently word-aligned.
module fetch_pc_unit
   import fetch_pc_unit_pkg::*;
#(
   parameter int unsigned      XLEN     = XLEN_DEF,
   parameter logic [XLEN-1:0]  RESET_PC = 32'h4000_0000,
   parameter int unsigned      CNT_W    = CNT_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   fetch_pc_unit_if.master    bus
);

   localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(INSN_BYTES - 1);

   fetch_state_e     state_q, state_d;
   logic [XLEN-1:0]  pc_q, pc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   pc_sel_e          pc_sel;
   logic [XLEN-1:0]  tgt;
   logic             imem_en;
   logic             if_valid;
   logic             fetch_exc;

   // Low address bits are dropped; with the trap enabled they are checked first.
   assign tgt = bus.redir_target & ALIGN_MASK;

`ifdef FETCH_MISALIGN_TRAP_EN
   logic            misaligned;
   logic [XLEN-1:0] exc_pc_q, exc_pc_d;

   assign misaligned = |(bus.redir_target & ~ALIGN_MASK);
`endif

   // Next-state, PC select and output decode; reset forces the reset vector.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pc_sel    = PC_SEL_HOLD;
      imem_en   = 1'b0;
      if_valid  = 1'b0;
      fetch_exc = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      exc_pc_d  = exc_pc_q;
`endif
      if (rst) begin
         pc_sel  = PC_SEL_RESET;
         state_d = FETCH_BOOT;
      end else begin
         case (state_q)
            FETCH_BOOT: begin
               imem_en = 1'b1;
               pc_sel  = PC_SEL_RESET;
               state_d = FETCH_RUN;
            end
            FETCH_RUN: begin
               imem_en = 1'b1;
               if (bus.redir_valid) begin
                  // Wrong-path word squashed; redirect wins over stall.
`ifdef FETCH_MISALIGN_TRAP_EN
                  if (misaligned) begin
                     pc_sel   = PC_SEL_HOLD;
                     state_d  = FETCH_TRAP;
                     exc_pc_d = bus.redir_target;
                  end else begin
                     pc_sel = PC_SEL_TGT;
                  end
`else
                  pc_sel = PC_SEL_TGT;
`endif
               end else if (bus.stall) begin
                  // Re-read the same address so IMEM dout stays stable.
                  if_valid = 1'b1;
                  pc_sel   = PC_SEL_HOLD;
               end else begin
                  if_valid = 1'b1;
                  pc_sel   = PC_SEL_INC;
                  cnt_d    = cnt_q + CNT_W'(1);
               end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            FETCH_TRAP: begin
               fetch_exc = 1'b1;
               pc_sel    = PC_SEL_HOLD;
            end
`endif
            default: begin
               state_d = FETCH_BOOT;
               pc_sel  = PC_SEL_RESET;
            end
         endcase
      end
   end

   pc_next_mux #(
      .XLEN (XLEN)
   ) u_pc_next_mux (
      .sel_i      (pc_sel),
      .reset_pc_i (RESET_PC),
      .tgt_i      (tgt),
      .pc_q_i     (pc_q),
      .pc_next_o  (pc_d)
   );

   // State, PC and fetch counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FETCH_BOOT;
         pc_q    <= RESET_PC;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef FETCH_MISALIGN_TRAP_EN
   // Captured offending redirect target, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         exc_pc_q <= '0;
      end else begin
         exc_pc_q <= exc_pc_d;
      end
   end

   assign bus.exc_pc = exc_pc_q;
`else
   assign bus.exc_pc = '0;
`endif

   // The next PC is exactly the address being read, since dout lags one cycle.
   assign bus.imem_addr = pc_d;
   assign bus.imem_en   = imem_en;
   assign bus.if_pc     = pc_q;
   assign bus.if_valid  = if_valid;
   assign bus.fetch_cnt = cnt_q;
   assign bus.fetch_exc = fetch_exc;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: boot, stall, redirect, alignment, wrap and
// reset-during-redirect, with hand-computed expected values.
// Honours FETCH_MISALIGN_TRAP_EN for the misaligned-redirect expectations.
module tb_fetch_pc_unit;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   fetch_pc_unit_if #(.XLEN(32), .CNT_W(32)) bus ();

   fetch_pc_unit #(
      .XLEN     (32),
      .RESET_PC (32'h4000_0000),
      .CNT_W    (32)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance one edge; inputs are then driven 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Let combinational outputs settle before sampling.
   task automatic settle();
      #1;
   endtask

   initial begin
      rst              = 1'b1;
      bus.stall        = 1'b0;
      bus.redir_valid  = 1'b0;
      bus.redir_target = '0;

      // T1: reset held three edges, then boot and sequential fetch.
      repeat (3) tick();
      settle();
      check_val("rst_imem_en",   32'(bus.imem_en),   32'd0);
      check_val("rst_if_valid",  32'(bus.if_valid),  32'd0);
      check_val("rst_imem_addr", bus.imem_addr,      32'h4000_0000);
      check_val("rst_fetch_exc", 32'(bus.fetch_exc), 32'd0);
      check_val("rst_fetch_cnt", bus.fetch_cnt,      32'd0);
      rst = 1'b0;
      settle();
      check_val("boot_imem_en",   32'(bus.imem_en),  32'd1);
      check_val("boot_if_valid",  32'(bus.if_valid), 32'd0);
      check_val("boot_imem_addr", bus.imem_addr,     32'h4000_0000);
      tick();
      settle();
      check_val("run1_if_pc",     bus.if_pc,         32'h4000_0000);
      check_val("run1_if_valid",  32'(bus.if_valid), 32'd1);
      check_val("run1_imem_addr", bus.imem_addr,     32'h4000_0004);
      tick();
      settle();
      check_val("run2_if_pc",     bus.if_pc,         32'h4000_0004);
      check_val("run2_fetch_cnt", bus.fetch_cnt,     32'd1);
      tick();
      settle();
      check_val("run3_if_pc",     bus.if_pc,         32'h4000_0008);
      check_val("run3_fetch_cnt", bus.fetch_cnt,     32'd2);

      // T2: two stalled cycles at 0x4000_0008, then release.
      bus.stall = 1'b1;
      settle();
      check_val("stall1_imem_addr", bus.imem_addr,     32'h4000_0008);
      check_val("stall1_if_valid",  32'(bus.if_valid), 32'd1);
      tick();
      settle();
      check_val("stall2_if_pc",     bus.if_pc,         32'h4000_0008);
      check_val("stall2_imem_addr", bus.imem_addr,     32'h4000_0008);
      check_val("stall2_fetch_cnt", bus.fetch_cnt,     32'd2);
      tick();
      bus.stall = 1'b0;
      settle();
      check_val("rel_if_pc",     bus.if_pc,     32'h4000_0008);
      check_val("rel_fetch_cnt", bus.fetch_cnt, 32'd2);
      check_val("rel_imem_addr", bus.imem_addr, 32'h4000_000C);
      tick();
      settle();
      check_val("post_stall_if_pc", bus.if_pc,     32'h4000_000C);
      check_val("post_stall_cnt",   bus.fetch_cnt, 32'd3);

      // T3: redirect with simultaneous stall.
      bus.redir_valid  = 1'b1;
      bus.redir_target = 32'h4000_0100;
      bus.stall        = 1'b1;
      settle();
      check_val("redir_if_valid",  32'(bus.if_valid), 32'd0);
      check_val("redir_imem_addr", bus.imem_addr,     32'h4000_0100);
      tick();
      bus.redir_valid = 1'b0;
      bus.stall       = 1'b0;
      settle();
      check_val("tgt_if_pc",     bus.if_pc,         32'h4000_0100);
      check_val("tgt_if_valid",  32'(bus.if_valid), 32'd1);
      check_val("tgt_fetch_cnt", bus.fetch_cnt,     32'd3);
      check_val("tgt_imem_addr", bus.imem_addr,     32'h4000_0104);

      // T4: misaligned redirect target 0x4000_0102.
      bus.redir_valid  = 1'b1;
      bus.redir_target = 32'h4000_0102;
      settle();
      check_val("mis_if_valid",  32'(bus.if_valid),  32'd0);
      check_val("mis_fetch_exc", 32'(bus.fetch_exc), 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
      tick();
      bus.redir_valid = 1'b0;
      settle();
      check_val("trap_fetch_exc", 32'(bus.fetch_exc), 32'd1);
      check_val("trap_exc_pc",    bus.exc_pc,         32'h4000_0102);
      check_val("trap_if_valid",  32'(bus.if_valid),  32'd0);
      check_val("trap_imem_en",   32'(bus.imem_en),   32'd0);
      check_val("trap_if_pc",     bus.if_pc,          32'h4000_0100);
      bus.redir_valid  = 1'b1;
      bus.redir_target = 32'h4000_0200;
      tick();
      bus.redir_valid = 1'b0;
      settle();
      check_val("trap_sticky_exc", 32'(bus.fetch_exc), 32'd1);
      check_val("trap_frozen_pc",  bus.if_pc,          32'h4000_0100);
`else
      check_val("mis_imem_addr", bus.imem_addr, 32'h4000_0100);
      tick();
      bus.redir_valid = 1'b0;
      settle();
      check_val("mis_next_if_pc", bus.if_pc,          32'h4000_0100);
      check_val("mis_next_valid", 32'(bus.if_valid),  32'd1);
      check_val("mis_exc_pc",     bus.exc_pc,         32'd0);
      check_val("mis_next_exc",   32'(bus.fetch_exc), 32'd0);
      check_val("mis_next_cnt",   bus.fetch_cnt,      32'd3);
`endif

      // Fresh reset (also the only exit from TRAP) before the wrap test.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      settle();
      check_val("rerst_fetch_exc", 32'(bus.fetch_exc), 32'd0);
      check_val("rerst_fetch_cnt", bus.fetch_cnt,      32'd0);
      check_val("rerst_exc_pc",    bus.exc_pc,         32'd0);
      tick();
      settle();
      check_val("reboot_if_pc", bus.if_pc, 32'h4000_0000);

      // T5: redirect to the top word, then PC+4 wraps to zero.
      bus.redir_valid  = 1'b1;
      bus.redir_target = 32'hFFFF_FFFC;
      settle();
      check_val("wrap_redir_addr", bus.imem_addr, 32'hFFFF_FFFC);
      tick();
      bus.redir_valid = 1'b0;
      settle();
      check_val("wrap_top_if_pc", bus.if_pc,     32'hFFFF_FFFC);
      check_val("wrap_imem_addr", bus.imem_addr, 32'h0000_0000);
      tick();
      settle();
      check_val("wrap_if_pc",     bus.if_pc,         32'h0000_0000);
      check_val("wrap_if_valid",  32'(bus.if_valid), 32'd1);
      check_val("wrap_fetch_cnt", bus.fetch_cnt,     32'd1);
      tick();
      settle();
      check_val("wrap_next_if_pc", bus.if_pc,     32'h0000_0004);
      check_val("wrap_next_cnt",   bus.fetch_cnt, 32'd2);

      // T6: reset asserted in the same cycle as a redirect.
      bus.redir_valid  = 1'b1;
      bus.redir_target = 32'h4000_0200;
      rst              = 1'b1;
      settle();
      check_val("rstredir_imem_en",   32'(bus.imem_en),  32'd0);
      check_val("rstredir_if_valid",  32'(bus.if_valid), 32'd0);
      check_val("rstredir_imem_addr", bus.imem_addr,     32'h4000_0000);
      tick();
      rst             = 1'b0;
      bus.redir_valid = 1'b0;
      settle();
      check_val("rstredir_boot_cnt",   bus.fetch_cnt,     32'd0);
      check_val("rstredir_boot_addr",  bus.imem_addr,     32'h4000_0000);
      check_val("rstredir_boot_en",    32'(bus.imem_en),  32'd1);
      check_val("rstredir_boot_valid", 32'(bus.if_valid), 32'd0);
      tick();
      settle();
      check_val("rstredir_run_if_pc", bus.if_pc,         32'h4000_0000);
      check_val("rstredir_run_valid", 32'(bus.if_valid), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Run-time bound in case the stimulus process stalls.
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
